id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode/operand-fetch stage. It sits directly upstream of the ALU and owns the 16x16 register file.
//  Each cycle it accepts one 16-bit instruction from fetch, reads operands rs=[7:4] and rt=[3:0],
//  and registers them into the ID/EX pipeline register.
//  ex_ain / ex_bin / ex_instr drive the ALU's Ain / Bin / Instruction inputs; writeback returns on the wb_* port.
// PARAMETERS
//  DATA_W    16  register/operand width
//  REG_AW    4   register address width (2**REG_AW registers)
//  ZERO_REG  1   1: R0 reads as 0 and writes to R0 are dropped; 0: R0 is an ordinary register
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       synchronous reset, active-high
//  if_valid  in   1       if_instr holds a valid instruction
//  if_instr  in   16      instruction: op=[15:12] rd=[11:8] rs=[7:4] rt/imm=[3:0]
//  id_ready  out  1       stage can accept this cycle (= !stall)
//  stall     in   1       hold the ID/EX register (EX/hazard not ready)
//  flush     in   1       kill the ID/EX contents (taken branch/jump)
//  wb_en     in   1       register-file write enable
//  wb_addr   in   REG_AW  write address
//  wb_data   in   DATA_W  write data
//  ex_valid  out  1       ID/EX holds a live instruction
//  ex_instr  out  16      instruction forwarded to ALU
//  ex_ain    out  DATA_W  R[rs] captured at decode
//  ex_bin    out  DATA_W  R[rt] captured at decode
//  ex_dest   out  REG_AW  writeback destination
//  ex_wr     out  1       instruction writes a register
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge; wins over all other inputs):
//    all registers <= 0; ex_valid, ex_wr = 0; ex_instr, ex_ain, ex_bin, ex_dest = 0.
//    A reset mid-stall or mid-flush discards everything.
//  - Capture: at a posedge with if_valid & !stall & !flush, ID/EX loads the decoded instruction
//    and ex_valid <= 1. Latency is 1 cycle from if_instr to ex_*.
//  - At a posedge with !if_valid & !stall & !flush: ex_valid <= 0 (bubble). The other ex_* fields are don't-care.
//  - Stall (and !flush): every ex_* output holds its value. if_instr is not consumed;
//    fetch must hold it until id_ready=1.
//  - Flush has priority over stall and capture: ex_valid <= 0 and ex_wr <= 0, and if_instr is dropped.
//  - Register-file write at the posedge when wb_en=1. It is independent of stall/flush.
//    It is dropped when wb_addr=0 and ZERO_REG=1.
//  - Reads are combinational from the array. Without the bypass, a same-cycle write to rs/rt
//    returns the OLD value.
//  - ex_wr = 1 for opcodes 0000,0001,0010,0011,0101,0110,1001,1010,1011,1100,1101.
//    ex_wr = 0 for 0100,0111,1000,1110,1111.
//  - ex_dest = rd, except JAL (1001), where ex_dest = all-ones (link register R15).
//  - Opcodes 1110/1111 pass through with ex_valid=1 and ex_wr=0; no trap.
//  - Reading address 0 with ZERO_REG=1 returns 0 regardless of wb activity.
// CONFIGURATION
//  DECODE_BYPASS_EN defined: if wb_en and wb_addr equals rs (or rt), and the address is not a
//    suppressed R0, the operand takes wb_data that same cycle (write-through bypass).
//  DECODE_BYPASS_EN undefined: no bypass. The hazard unit must stall one extra cycle for a
//    writeback to a source register in the same cycle.
// TESTING
//  1 Reset: rst=1 for 2 cycles with if_valid=1 -> ex_valid=0, ex_wr=0, all ex_* 0.
//    Read R1..R15 afterwards -> 0.
//  2 Write then read: wb R3=0x1234, R4=0x0F0F. Next cycle issue 0x0534 (ADD r5,r3,r4)
//    -> next cycle ex_ain=0x1234, ex_bin=0x0F0F, ex_dest=5, ex_wr=1, ex_valid=1.
//  3 Stall/flush: with ID/EX holding 0x0534, stall=1 for 3 cycles -> outputs constant, id_ready=0.
//    Then flush=1 with stall=1 -> ex_valid=0 next cycle.
//  4 Same-cycle writeback: wb R3=0xBEEF in the cycle 0x0534 is captured
//    -> ex_ain=0xBEEF with DECODE_BYPASS_EN, old 0x1234 without it.
//  5 Zero register and decode: wb R0=0xFFFF, then issue 0x0100 -> ex_ain=0.
//    Issue 0x7123 (BEQ) -> ex_wr=0. Issue 0x9000 (JAL) -> ex_dest=15, ex_wr=1.
//    Issue 0xE000 -> ex_valid=1, ex_wr=0.
//  6 Back-to-back: 4 consecutive valid instructions with no stall -> 4 consecutive ex_valid=1 cycles
//    with matching ex_instr order. if_valid=0 gap -> one bubble.

Source files
------------

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: owns the register file and the ID/EX pipeline register.
// Optional macro DECODE_BYPASS_EN adds a write-through bypass from the writeback port to the operand reads.
module id_stage #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [15:0]       if_instr,
   output logic              id_ready,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [15:0]       ex_instr,
   output logic [DATA_W-1:0] ex_ain,
   output logic [DATA_W-1:0] ex_bin,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_wr
);

   localparam int unsigned NREGS  = 2 ** REG_AW;
   localparam logic [3:0]  OP_JAL = 4'b1001;

   logic [DATA_W-1:0] rf [NREGS];
   logic [3:0]        op;
   logic [REG_AW-1:0] rd, rs, rt;
   logic              wb_live;
   logic [DATA_W-1:0] ain_c, bin_c;
   logic              wr_c;
   logic [REG_AW-1:0] dest_c;

   assign op       = if_instr[15:12];
   assign rd       = REG_AW'(if_instr[11:8]);
   assign rs       = REG_AW'(if_instr[7:4]);
   assign rt       = REG_AW'(if_instr[3:0]);
   assign id_ready = !stall;

   // A write to R0 is discarded when R0 is hardwired to zero.
   assign wb_live = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (wb_live) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // Operand read; the R0 override is applied last so it beats the bypass.
   always_comb begin
      ain_c = rf[rs];
      bin_c = rf[rt];
`ifdef DECODE_BYPASS_EN
      if (wb_live && (wb_addr == rs)) ain_c = wb_data;
      if (wb_live && (wb_addr == rt)) bin_c = wb_data;
`endif
      if ((ZERO_REG != 0) && (rs == '0)) ain_c = '0;
      if ((ZERO_REG != 0) && (rt == '0)) bin_c = '0;
   end

   // Register-writing opcodes; JAL links into the top register.
   always_comb begin
      wr_c   = 1'b0;
      dest_c = rd;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
         4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101: wr_c = 1'b1;
         default:                                      wr_c = 1'b0;
      endcase
      if (op == OP_JAL) dest_c = '1;
   end

   // ID/EX register: reset > flush > stall > capture/bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_wr    <= 1'b0;
         ex_instr <= '0;
         ex_ain   <= '0;
         ex_bin   <= '0;
         ex_dest  <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_wr    <= 1'b0;
      end else if (!stall) begin
         ex_valid <= if_valid;
         if (if_valid) begin
            ex_instr <= if_instr;
            ex_ain   <= ain_c;
            ex_bin   <= bin_c;
            ex_dest  <= dest_c;
            ex_wr    <= wr_c;
         end else begin
            ex_wr    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table plus hand sequences, expectations queued at drive and checked one cycle later.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst, if_valid, stall, flush, wb_en;
   logic [15:0] if_instr, wb_data;
   logic [3:0]  wb_addr;
   logic        id_ready, ex_valid, ex_wr;
   logic [15:0] ex_instr, ex_ain, ex_bin;
   logic [3:0]  ex_dest;

`ifdef DECODE_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   id_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
      .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_ain(ex_ain), .ex_bin(ex_bin),
      .ex_dest(ex_dest), .ex_wr(ex_wr)
   );

   always #5 clk = ~clk;

   // mode: 0 = check ex_valid only, 1 = also ex_wr, 2 = every ex_* field
   typedef struct {
      logic        rst, v, st, fl, we;
      logic [15:0] instr;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        ev, ew;
      logic [15:0] ei, ea, eb;
      logic [3:0]  ed;
      int          mode;
   } vec_t;

   int   passed = 0;
   int   total  = 0;
   vec_t sb[$];
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic v, input logic [15:0] i, input logic st, input logic fl,
                               input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic ev, input logic [15:0] ei, input logic [15:0] ea,
                               input logic [15:0] eb, input logic [3:0] ed, input logic ew,
                               input int md);
      vec_t t;
      t.rst = 1'b0; t.v = v; t.instr = i; t.st = st; t.fl = fl; t.we = we; t.wa = wa; t.wd = wd;
      t.ev = ev; t.ei = ei; t.ea = ea; t.eb = eb; t.ed = ed; t.ew = ew; t.mode = md;
      return t;
   endfunction

   // One cycle: apply inputs, queue the expectation, check after the edge.
   task automatic drive(input string tag, input vec_t t);
      vec_t e;
      rst = t.rst; if_valid = t.v; if_instr = t.instr; stall = t.st; flush = t.fl;
      wb_en = t.we; wb_addr = t.wa; wb_data = t.wd;
      #1;
      chk({tag, " id_ready"}, 16'(id_ready), 16'(!t.st));
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, " ex_valid"}, 16'(ex_valid), 16'(e.ev));
      if (e.mode >= 1) chk({tag, " ex_wr"}, 16'(ex_wr), 16'(e.ew));
      if (e.mode == 2) begin
         chk({tag, " ex_instr"}, ex_instr, e.ei);
         chk({tag, " ex_ain"}, ex_ain, e.ea);
         chk({tag, " ex_bin"}, ex_bin, e.eb);
         chk({tag, " ex_dest"}, 16'(ex_dest), 16'(e.ed));
      end
   endtask

   initial begin
      vec_t        t;
      logic [15:0] wrmask;
      logic [15:0] ins;
      logic [3:0]  op;

      rst = 1'b1; if_valid = 1'b0; if_instr = '0; stall = 1'b0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      @(posedge clk);
      #1;

      // Fill the register file so the reset that follows has something to clear.
      t = mk(0, 16'h0, 0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
      t.rst = 1'b1;
      drive("init", t);
      for (int i = 1; i < 16; i++)
         drive($sformatf("fill%0d", i),
               mk(0, 16'h0, 0, 0, 1, 4'(i), 16'hA000 | 16'(i), 0, 0, 0, 0, 0, 0, 0));

      // Reset with a valid instruction and writeback present: everything zero.
      for (int i = 0; i < 2; i++) begin
         t = mk(1, 16'h1234, 0, 0, 1, 4'h7, 16'hFFFF, 0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 2);
         t.rst = 1'b1;
         drive($sformatf("reset%0d", i), t);
      end
      for (int i = 1; i < 16; i++) begin
         ins = {4'h2, 4'h0, 4'(i), 4'(i)};
         drive($sformatf("rd_r%0d", i), mk(1, ins, 0, 0, 0, 4'h0, 16'h0, 1, ins, 16'h0, 16'h0, 4'h0, 1, 2));
      end

      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h3, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h4, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'h1234, 16'h0F0F, 4'h5, 1, 2));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1, 16'h0534, 1, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'h1234, 16'h0F0F, 4'h5, 1, 2));
      tbl.push_back(mk(1, 16'h0534, 1, 1, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 16'h0534, 0, 0, 1, 4'h3, 16'hBEEF, 1, 16'h0534, BYP ? 16'hBEEF : 16'h1234,
                       16'h0F0F, 4'h5, 1, 2));
      tbl.push_back(mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'hBEEF, 16'h0F0F, 4'h5, 1, 2));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0100, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0100, 16'h0, 16'h0, 4'h1, 1, 2));
      tbl.push_back(mk(1, 16'h0100, 0, 0, 1, 4'h0, 16'hFFFF, 1, 16'h0100, 16'h0, 16'h0, 4'h1, 1, 2));
      tbl.push_back(mk(1, 16'h7123, 0, 0, 0, 4'h0, 16'h0, 1, 16'h7123, 16'h0, 16'hBEEF, 4'h1, 0, 2));
      tbl.push_back(mk(1, 16'h9000, 0, 0, 0, 4'h0, 16'h0, 1, 16'h9000, 16'h0, 16'h0, 4'hF, 1, 2));
      tbl.push_back(mk(1, 16'hE000, 0, 0, 0, 4'h0, 16'h0, 1, 16'hE000, 16'h0, 16'h0, 4'h0, 0, 2));
      tbl.push_back(mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'hBEEF, 16'h0F0F, 4'h5, 1, 2));
      tbl.push_back(mk(1, 16'h4143, 0, 0, 0, 4'h0, 16'h0, 1, 16'h4143, 16'h0F0F, 16'hBEEF, 4'h1, 0, 2));
      tbl.push_back(mk(1, 16'hC234, 0, 0, 0, 4'h0, 16'h0, 1, 16'hC234, 16'hBEEF, 16'h0F0F, 4'h2, 1, 2));
      tbl.push_back(mk(1, 16'h8F43, 0, 0, 0, 4'h0, 16'h0, 1, 16'h8F43, 16'h0F0F, 16'hBEEF, 4'hF, 0, 2));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h1213, 0, 0, 0, 4'h0, 16'h0, 1, 16'h1213, 16'h0, 16'hBEEF, 4'h2, 1, 2));
      tbl.push_back(mk(1, 16'h0534, 0, 1, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 16'h0534, 1, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'hBEEF, 16'h0F0F, 4'h5, 1, 2));
      foreach (tbl[i]) drive($sformatf("tbl%0d", i), tbl[i]);

      // Write-enable and destination decode for every opcode.
      wrmask = 16'h3E6F;
      for (int i = 0; i < 16; i++) begin
         op  = 4'(i);
         ins = {op, 4'h6, 4'h3, 4'h4};
         drive($sformatf("op%0d", i), mk(1, ins, 0, 0, 0, 4'h0, 16'h0, 1, ins, 16'hBEEF, 16'h0F0F,
                                         (op == 4'h9) ? 4'hF : 4'h6, wrmask[i], 2));
      end

      // Reset during a stall discards the held instruction and the register file.
      drive("pre_rst", mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'hBEEF, 16'h0F0F, 4'h5, 1, 2));
      t = mk(1, 16'h0534, 1, 1, 1, 4'h5, 16'h5555, 0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 2);
      t.rst = 1'b1;
      drive("mid_rst", t);
      drive("post_rst", mk(1, 16'h0534, 0, 0, 0, 4'h0, 16'h0, 1, 16'h0534, 16'h0, 16'h0, 4'h5, 1, 2));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
